fan_drive: RTL and testbench
============================

FAN_DRIVE -- requirements
Module: fan_drive

Interface
REQ-001 Parameters, one per line (name, default, meaning):
- PWM_DIV, 1000: i_clk cycles per PWM count step.
- RAMP_DIV, 100000: i_clk cycles per soft-start duty step.
- SEC_DIV, 100000000: i_clk cycles per timer second.
REQ-002 Ports, one per line (name, direction, width, meaning):
- i_clk, input, 1: clock.
- i_reset, input, 1: reset, asynchronous, active-high.
- i_fanState, input, 2: requested fan level 0..3 from the fan FSM.
- i_button_T, input, 1: one-cycle debounced timer-select pulse.
- o_pwm, output, 1: motor PWM drive.
- o_duty, output, 7: current applied duty 0..100.
- o_ramping, output, 1: high while o_duty differs from the target duty.
- o_remain_sec, output, 9: seconds left on the off-timer; 0 when idle.
- o_timerSel, output, 2: preset index 0..3.
- o_fanOff, output, 1: one-cycle request to the fan FSM to go to level 0.

Function
REQ-003 Target duty: level 0->0, 1->33, 2->66, 3->100.
REQ-004 The PWM counter shall step 0..99 once per PWM_DIV clocks and wrap from 99 to 0.
REQ-005 o_pwm shall be (pwm_cnt < latched duty); duty is latched only when pwm_cnt wraps to 0 (glitch-free); duty 100 gives constant 1, duty 0 constant 0.
REQ-006 Every RAMP_DIV clocks, o_duty shall move by 1 toward the target.
REQ-007 Target 0 shall force o_duty to 0 on the next clock, with no ramp.
REQ-008 A target change mid-ramp shall redirect the ramp from the current o_duty without restarting.
REQ-009 o_ramping = (o_duty != target), combinational.
REQ-010 Timer FSM states: IDLE, ARMED, EXPIRE.
REQ-011 Presets: index 0->0 s, 1->60 s, 2->180 s, 3->300 s.
REQ-012 A press in IDLE or ARMED with i_fanState != 0 shall advance o_timerSel (3 wraps to 0) and load o_remain_sec with the new preset.
- Preset 0 -> IDLE.
- Otherwise -> ARMED, second prescaler cleared.
REQ-013 A press while i_fanState == 0 shall be ignored.
REQ-014 In ARMED, o_remain_sec shall decrement once per SEC_DIV clocks; the decrement to 0 shall go to EXPIRE.
REQ-015 EXPIRE shall assert o_fanOff for exactly one cycle, then go to IDLE with o_timerSel = 0.
REQ-016 i_fanState == 0 while ARMED shall cancel the timer: go to IDLE, o_timerSel = 0, o_remain_sec = 0, no o_fanOff.
REQ-017 A press in the same cycle as the final decrement shall win: reload the next preset, no EXPIRE.
REQ-018 o_remain_sec shall be 9 bits, unsigned, saturating at 0.

Reset
REQ-019 On i_reset, all registers clear immediately: pwm_cnt, prescalers, o_duty = 0, o_pwm = 0, o_remain_sec = 0, o_timerSel = 0, o_fanOff = 0, state IDLE.
REQ-020 Reset mid-ramp or mid-countdown shall discard all progress; after release the block restarts from the reset values.

Structure
REQ-021 A shared package shall hold the timer-state encodings, the duty table (0/33/66/100) and the preset table (0/60/180/300).
REQ-022 The three tick generators shall be instances of one sub-module, tick_gen (parameter DIV, output a one-cycle tick).
REQ-023 Target: 150-300 lines of RTL.

Verification
REQ-024 Benches shall use PWM_DIV=1, RAMP_DIV=2, SEC_DIV=10, and cover:
- i_fanState 0->3 -> o_duty rises 0 to 100 by 1 every 2 clocks, o_ramping high until 100, then o_pwm constant 1.
- i_fanState 2 steady with duty 66 -> over each 100-step PWM period, o_pwm high exactly 66 counts.
- Ramp to 40 then i_fanState 0 -> o_duty = 0 on the next clock, o_pwm low.
- Level 1, one press -> o_timerSel=1, o_remain_sec=60; after 600 clocks one o_fanOff pulse, IDLE, o_timerSel=0.
- ARMED with 30 s left, i_fanState -> 0 -> IDLE, o_remain_sec=0, no o_fanOff; a press at level 0 leaves o_timerSel=0.
- Press coincident with the final decrement -> o_remain_sec=180, no o_fanOff; i_reset mid-countdown -> all outputs 0.

Source files
------------

// File: rtl/fan_drive_pkg.sv
// Shared definitions for the fan drive: timer-state encodings, duty and preset tables.
package fan_drive_pkg;

   typedef logic [1:0] timer_state_t;

   localparam timer_state_t ST_IDLE   = 2'd0;
   localparam timer_state_t ST_ARMED  = 2'd1;
   localparam timer_state_t ST_EXPIRE = 2'd2;

   localparam logic [6:0] PWM_LAST = 7'd99;

   function automatic logic [6:0] duty_of(input logic [1:0] level);
      case (level)
         2'd0:    duty_of = 7'd0;
         2'd1:    duty_of = 7'd33;
         2'd2:    duty_of = 7'd66;
         default: duty_of = 7'd100;
      endcase
   endfunction

   function automatic logic [8:0] preset_of(input logic [1:0] idx);
      case (idx)
         2'd0:    preset_of = 9'd0;
         2'd1:    preset_of = 9'd60;
         2'd2:    preset_of = 9'd180;
         default: preset_of = 9'd300;
      endcase
   endfunction

endpackage

// File: rtl/fan_drive_tick_gen.sv
// Free-running divider producing a one-cycle tick every DIV clocks; clear restarts the count.
module tick_gen #(
   parameter int DIV = 2
) (
   input  logic i_clk,
   input  logic i_reset,
   input  logic clear,
   output logic tick
);

   localparam int W = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [W-1:0] LAST = W'(DIV - 1);

   logic [W-1:0] cnt;

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset)
         cnt <= '0;
      else if (clear || cnt == LAST)
         cnt <= '0;
      else
         cnt <= cnt + 1'b1;
   end

   assign tick = (cnt == LAST);

endmodule

// File: rtl/fan_drive.sv
// Fan motor drive: soft-start duty ramp, glitch-free PWM and a preset off-timer.
module fan_drive
   import fan_drive_pkg::*;
#(
   parameter int PWM_DIV  = 1000,
   parameter int RAMP_DIV = 100000,
   parameter int SEC_DIV  = 100000000
) (
   input  logic       i_clk,
   input  logic       i_reset,
   input  logic [1:0] i_fanState,
   input  logic       i_button_T,
   output logic       o_pwm,
   output logic [6:0] o_duty,
   output logic       o_ramping,
   output logic [8:0] o_remain_sec,
   output logic [1:0] o_timerSel,
   output logic       o_fanOff
);

   logic         pwm_tick;
   logic         ramp_tick;
   logic         sec_tick;
   logic         sec_clear;
   logic         press_ok;
   logic [1:0]   next_sel;
   logic [6:0]   target;
   logic [6:0]   pwm_cnt;
   logic [6:0]   duty_lat;
   timer_state_t state;

   tick_gen #(.DIV(PWM_DIV))  u_pwm_tick  (.i_clk(i_clk), .i_reset(i_reset), .clear(1'b0),     .tick(pwm_tick));
   tick_gen #(.DIV(RAMP_DIV)) u_ramp_tick (.i_clk(i_clk), .i_reset(i_reset), .clear(1'b0),     .tick(ramp_tick));
   tick_gen #(.DIV(SEC_DIV))  u_sec_tick  (.i_clk(i_clk), .i_reset(i_reset), .clear(sec_clear), .tick(sec_tick));

   assign target    = duty_of(i_fanState);
   assign o_ramping = (o_duty != target);

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset)
         o_duty <= 7'd0;
      else if (target == 7'd0)
         o_duty <= 7'd0;
      else if (ramp_tick && o_duty < target)
         o_duty <= o_duty + 7'd1;
      else if (ramp_tick && o_duty > target)
         o_duty <= o_duty - 7'd1;
   end

   // Duty is only sampled at the period boundary so a pulse is never truncated mid-period.
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         pwm_cnt  <= 7'd0;
         duty_lat <= 7'd0;
      end else if (pwm_tick) begin
         if (pwm_cnt == PWM_LAST) begin
            pwm_cnt  <= 7'd0;
            duty_lat <= o_duty;
         end else begin
            pwm_cnt <= pwm_cnt + 7'd1;
         end
      end
   end

   assign o_pwm = (pwm_cnt < duty_lat);

   assign press_ok  = i_button_T && (i_fanState != 2'd0) && (state != ST_EXPIRE);
   assign next_sel  = o_timerSel + 2'd1;
   assign sec_clear = press_ok && (next_sel != 2'd0);
   assign o_fanOff  = (state == ST_EXPIRE);

   // A press takes priority over the countdown, so a press on the last second reloads instead of expiring.
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         state        <= ST_IDLE;
         o_timerSel   <= 2'd0;
         o_remain_sec <= 9'd0;
      end else begin
         case (state)
            ST_IDLE, ST_ARMED: begin
               if (i_fanState == 2'd0) begin
                  state        <= ST_IDLE;
                  o_timerSel   <= 2'd0;
                  o_remain_sec <= 9'd0;
               end else if (press_ok) begin
                  o_timerSel   <= next_sel;
                  o_remain_sec <= preset_of(next_sel);
                  state        <= (next_sel == 2'd0) ? ST_IDLE : ST_ARMED;
               end else if (state == ST_ARMED && sec_tick) begin
                  if (o_remain_sec <= 9'd1) begin
                     o_remain_sec <= 9'd0;
                     state        <= ST_EXPIRE;
                  end else begin
                     o_remain_sec <= o_remain_sec - 9'd1;
                  end
               end
            end
            default: begin
               state        <= ST_IDLE;
               o_timerSel   <= 2'd0;
               o_remain_sec <= 9'd0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_fan_drive.sv
// Directed bench for fan_drive with short dividers (PWM 1, ramp 2, second 10 clocks).
module tb_fan_drive;

   logic       i_clk = 1'b0;
   logic       i_reset;
   logic [1:0] i_fanState;
   logic       i_button_T;
   logic       o_pwm;
   logic [6:0] o_duty;
   logic       o_ramping;
   logic [8:0] o_remain_sec;
   logic [1:0] o_timerSel;
   logic       o_fanOff;

   int tests_run    = 0;
   int tests_failed = 0;

   fan_drive #(.PWM_DIV(1), .RAMP_DIV(2), .SEC_DIV(10)) dut (
      .i_clk       (i_clk),
      .i_reset     (i_reset),
      .i_fanState  (i_fanState),
      .i_button_T  (i_button_T),
      .o_pwm       (o_pwm),
      .o_duty      (o_duty),
      .o_ramping   (o_ramping),
      .o_remain_sec(o_remain_sec),
      .o_timerSel  (o_timerSel),
      .o_fanOff    (o_fanOff)
   );

   always #5 i_clk = ~i_clk;

   task automatic tick();
      @(posedge i_clk);
      #1;
   endtask

   task automatic ticks(input int n);
      for (int k = 0; k < n; k++) tick();
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests_run++;
      assert (obs === exp) else begin
         tests_failed++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic press();
      i_button_T = 1'b1;
      tick();
      i_button_T = 1'b0;
   endtask

   task automatic count_pwm_high(output int highs);
      highs = 0;
      for (int k = 0; k < 100; k++) begin
         if (o_pwm) highs++;
         tick();
      end
   endtask

   initial begin
      int n;
      int bad;
      int highs;
      int pulses;

      // Reset state
      i_reset    = 1'b1;
      i_fanState = 2'd0;
      i_button_T = 1'b0;
      ticks(3);
      chk("rst_duty", o_duty, 0);
      chk("rst_pwm", o_pwm, 0);
      chk("rst_remain", o_remain_sec, 0);
      chk("rst_sel", o_timerSel, 0);
      chk("rst_fanoff", o_fanOff, 0);
      chk("rst_ramping", o_ramping, 0);
      i_reset = 1'b0;
      tick();

      // Soft start 0 -> 100, one step every two clocks
      i_fanState = 2'd3;
      n = 0;
      while (o_duty == 7'd0 && n < 4) begin tick(); n++; end
      chk("ramp_start", o_duty, 1);
      bad = 0;
      for (int d = 1; d < 100; d++) begin
         if (o_ramping !== 1'b1) bad++;
         tick();
         if (o_duty !== 7'(d)) bad++;
         tick();
         if (o_duty !== 7'(d + 1)) bad++;
      end
      chk("ramp_step_errors", bad, 0);
      chk("ramp_final_duty", o_duty, 100);
      chk("ramp_final_ramping", o_ramping, 0);
      ticks(100);
      count_pwm_high(highs);
      chk("pwm_duty100_highs", highs, 100);

      // Level 2: ramp down to 66, then 66 highs per period
      i_fanState = 2'd2;
      ticks(70);
      chk("lvl2_duty", o_duty, 66);
      chk("lvl2_ramping", o_ramping, 0);
      ticks(100);
      count_pwm_high(highs);
      chk("pwm_duty66_highs", highs, 66);

      // Target 0 drops duty immediately
      i_fanState = 2'd0;
      tick();
      chk("off_from66_duty", o_duty, 0);

      // Ramp to 40, redirect to 33 mid-ramp, then force off
      i_fanState = 2'd3;
      n = 0;
      while (o_duty != 7'd40 && n < 100) begin tick(); n++; end
      chk("reach40", o_duty, 40);
      i_fanState = 2'd1;
      tick();
      chk("redirect_hold", o_duty, 40);
      tick();
      chk("redirect_step", o_duty, 39);
      i_fanState = 2'd0;
      tick();
      chk("off_midramp_duty", o_duty, 0);
      chk("off_midramp_ramping", o_ramping, 0);
      ticks(100);
      count_pwm_high(highs);
      chk("pwm_duty0_highs", highs, 0);

      // Level 1, one press -> 60 s, expiry after 600 clocks
      i_fanState = 2'd1;
      tick();
      press();
      chk("t60_sel", o_timerSel, 1);
      chk("t60_remain", o_remain_sec, 60);
      pulses = 0;
      for (int k = 0; k < 10; k++) begin tick(); if (o_fanOff) pulses++; end
      chk("t60_first_dec", o_remain_sec, 59);
      for (int k = 0; k < 589; k++) begin tick(); if (o_fanOff) pulses++; end
      chk("t60_last_second", o_remain_sec, 1);
      chk("t60_no_early_off", pulses, 0);
      tick();
      chk("t60_fanoff", o_fanOff, 1);
      chk("t60_remain_zero", o_remain_sec, 0);
      tick();
      chk("t60_fanoff_one_cycle", o_fanOff, 0);
      chk("t60_sel_cleared", o_timerSel, 0);
      pulses = 0;
      for (int k = 0; k < 30; k++) begin tick(); if (o_fanOff) pulses++; end
      chk("t60_idle_no_pulse", pulses, 0);
      chk("t60_idle_remain", o_remain_sec, 0);

      // Cancel with 30 s left
      press();
      chk("cancel_armed_remain", o_remain_sec, 60);
      ticks(300);
      chk("cancel_remain30", o_remain_sec, 30);
      i_fanState = 2'd0;
      tick();
      chk("cancel_remain", o_remain_sec, 0);
      chk("cancel_sel", o_timerSel, 0);
      pulses = 0;
      for (int k = 0; k < 20; k++) begin if (o_fanOff) pulses++; tick(); end
      chk("cancel_no_fanoff", pulses, 0);
      press();
      chk("press_lvl0_sel", o_timerSel, 0);
      chk("press_lvl0_remain", o_remain_sec, 0);

      // Press coincident with the final decrement
      i_fanState = 2'd1;
      tick();
      press();
      chk("coinc_start", o_remain_sec, 60);
      ticks(599);
      chk("coinc_pre", o_remain_sec, 1);
      press();
      chk("coinc_sel", o_timerSel, 2);
      chk("coinc_remain", o_remain_sec, 180);
      chk("coinc_no_fanoff", o_fanOff, 0);
      tick();
      chk("coinc_no_fanoff_next", o_fanOff, 0);
      ticks(9);
      chk("coinc_next_dec", o_remain_sec, 179);

      // Asynchronous reset mid-countdown
      #2;
      i_reset = 1'b1;
      #1;
      chk("arst_remain", o_remain_sec, 0);
      chk("arst_sel", o_timerSel, 0);
      chk("arst_duty", o_duty, 0);
      chk("arst_pwm", o_pwm, 0);
      chk("arst_fanoff", o_fanOff, 0);
      chk("arst_ramping", o_ramping, 1);
      tick();
      i_reset = 1'b0;
      pulses = 0;
      for (int k = 0; k < 30; k++) begin tick(); if (o_fanOff) pulses++; end
      chk("post_rst_remain", o_remain_sec, 0);
      chk("post_rst_sel", o_timerSel, 0);
      chk("post_rst_no_fanoff", pulses, 0);
      chk("post_rst_duty_restart", o_duty, 15);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
